// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared helpers for the pipelined fixed-point multiplier.
// Saturation bounds, rounding constant and parameter legality.
package fp_mult_pkg;

    function automatic logic [63:0] sat_max(input int width, input bit is_signed);
        if (is_signed)
            return (64'd1 << (width - 1)) - 64'd1;
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width, input bit is_signed);
        if (is_signed)
            return 64'd1 << (width - 1);
        return 64'd0;
    endfunction

    function automatic logic [63:0] round_const(input int frac);
        if (frac > 0)
            return 64'd1 << (frac - 1);
        return 64'd0;
    endfunction

    function automatic bit params_ok(input int w, input int iw,
                                     input int fw, input int stages);
        return (w > 0) && (iw + fw == w) && (fw >= 0) && (stages >= 3);
    endfunction

endpackage

// File: rtl/fp_round_sat.sv
// fp_round_sat: combinational round, shift, overflow detect and clamp.
// Maps the widened product onto the WIDTH-bit fixed-point result.
module fp_round_sat
    import fp_mult_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int SIGNED     = 1,
    parameter int ROUND      = 0,
    parameter int SATURATE   = 0
) (
    input  logic [2*WIDTH:0]  p,
    output logic [WIDTH-1:0]  res,
    output logic              ovf
);
    localparam int PW = 2 * WIDTH + 1;
    localparam logic [PW-1:0] RND =
        (ROUND != 0 && FRAC_WIDTH > 0) ? PW'(round_const(FRAC_WIDTH)) : '0;
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(sat_max(WIDTH, SIGNED != 0));
    localparam logic [WIDTH-1:0] MINV = WIDTH'(sat_min(WIDTH, SIGNED != 0));

    logic [PW-1:0]    pr;
    logic [PW-1:0]    sh;
    logic [PW-WIDTH:0] hi;

    // round, rescale, then clamp toward the sign of the product
    always_comb begin
        pr = p + RND;
        if (SIGNED != 0)
            sh = $unsigned($signed(pr) >>> FRAC_WIDTH);
        else
            sh = pr >> FRAC_WIDTH;
        hi = sh[PW-1:WIDTH-1];
        if (SIGNED != 0)
            ovf = !((&hi) || !(|hi));
        else
            ovf = |sh[PW-1:WIDTH];
        res = sh[WIDTH-1:0];
        if (SATURATE != 0 && ovf)
            res = (SIGNED != 0 && p[PW-1]) ? MINV : MAXV;
    end

endmodule

// File: rtl/fp_mult_pipe_sat.sv
// fp_mult_pipe_sat: throughput-1 fixed-point multiplier, STAGES latency.
// Valid shift register steers a gated data pipe; round/sat at the end.
module fp_mult_pipe_sat
    import fp_mult_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int SIGNED     = 1,
    parameter int STAGES     = 3,
    parameter int ROUND      = 0,
    parameter int SATURATE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             go,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             overflow
);
    localparam int PW = 2 * WIDTH + 1;
    localparam int ND = STAGES - 2;

    if (!params_ok(WIDTH, INT_WIDTH, FRAC_WIDTH, STAGES)) begin : g_param_err
        $error("fp_mult_pipe_sat: illegal WIDTH/INT/FRAC split or STAGES < 3");
    end

    logic                 vld_d [STAGES];
    logic                 vld_q [STAGES];
    logic [WIDTH-1:0]     a_d, a_q, b_d, b_q;
    logic [2*WIDTH-1:0]   ax, bx, prod;
    logic [2*WIDTH-1:0]   prod_d [ND];
    logic [2*WIDTH-1:0]   prod_q [ND];
    logic [PW-1:0]        p;
    logic [WIDTH-1:0]     res, out_d, out_q;
    logic                 rs_ovf, ovf_d, ovf_q;

    // valid bits shift one stage per cycle, entering from go
    always_comb begin
        vld_d[0] = go;
        for (int i = 1; i < STAGES; i++)
            vld_d[i] = vld_q[i-1];
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_vld
        // valid pipe register; reset drops everything in flight
        always_ff @(posedge clk) begin
            if (reset) vld_q[i] <= 1'b0;
            else       vld_q[i] <= vld_d[i];
        end
    end

    // operand capture on issue
    always_comb begin
        a_d = go ? left  : a_q;
        b_d = go ? right : b_q;
    end

    // operand register
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // full-width product of the extended operands
    always_comb begin
        if (SIGNED != 0) begin
            ax = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            bx = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            ax = {{WIDTH{1'b0}}, a_q};
            bx = {{WIDTH{1'b0}}, b_q};
        end
        prod = ax * bx;
    end

    for (genvar k = 0; k < ND; k++) begin : g_dly
        if (k == 0) begin : g_first
            // product register, loaded when the operand stage is valid
            always_comb prod_d[k] = vld_q[0] ? prod : prod_q[k];
        end else begin : g_rest
            // retiming-only delay stage
            always_comb prod_d[k] = vld_q[k] ? prod_q[k-1] : prod_q[k];
        end

        // delay line register
        always_ff @(posedge clk) begin
            if (reset) prod_q[k] <= '0;
            else       prod_q[k] <= prod_d[k];
        end
    end

    // widen by one bit so rounding cannot wrap
    always_comb begin
        if (SIGNED != 0) p = {prod_q[ND-1][2*WIDTH-1], prod_q[ND-1]};
        else             p = {1'b0, prod_q[ND-1]};
    end

    fp_round_sat #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .SIGNED     (SIGNED),
        .ROUND      (ROUND),
        .SATURATE   (SATURATE)
    ) u_round_sat (
        .p   (p),
        .res (res),
        .ovf (rs_ovf)
    );

    // result holds between done pulses
    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        if (vld_q[STAGES-2]) begin
            out_d = res;
            ovf_d = rs_ovf;
        end
    end

    // output register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;
    assign done     = vld_q[STAGES-1];

endmodule

// File: tb/tb_fp_mult_pipe_sat.sv
// tb_fp_mult_pipe_sat: directed checks over five parameter sets.
// All instances share the stimulus; each task checks the relevant ones.
module tb_fp_mult_pipe_sat;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [7:0] left, right;

    logic [7:0] a_out, b_out, c_out, d_out, e_out;
    logic       a_done, b_done, c_done, d_done, e_done;
    logic       a_ovf, b_ovf, c_ovf, d_ovf, e_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Q4.4 signed, truncate, wrap
    fp_mult_pipe_sat #(.WIDTH(8), .INT_WIDTH(4), .FRAC_WIDTH(4), .SIGNED(1),
        .STAGES(3), .ROUND(0), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .left(left), .right(right), .go(go),
        .out(a_out), .done(a_done), .overflow(a_ovf));

    // Q4.4 signed, round half up
    fp_mult_pipe_sat #(.WIDTH(8), .INT_WIDTH(4), .FRAC_WIDTH(4), .SIGNED(1),
        .STAGES(3), .ROUND(1), .SATURATE(0)) u_b (
        .clk(clk), .reset(reset), .left(left), .right(right), .go(go),
        .out(b_out), .done(b_done), .overflow(b_ovf));

    // Q4.4 signed, saturate
    fp_mult_pipe_sat #(.WIDTH(8), .INT_WIDTH(4), .FRAC_WIDTH(4), .SIGNED(1),
        .STAGES(3), .ROUND(0), .SATURATE(1)) u_c (
        .clk(clk), .reset(reset), .left(left), .right(right), .go(go),
        .out(c_out), .done(c_done), .overflow(c_ovf));

    // signed integer, 5 stages
    fp_mult_pipe_sat #(.WIDTH(8), .INT_WIDTH(8), .FRAC_WIDTH(0), .SIGNED(1),
        .STAGES(5), .ROUND(0), .SATURATE(0)) u_d (
        .clk(clk), .reset(reset), .left(left), .right(right), .go(go),
        .out(d_out), .done(d_done), .overflow(d_ovf));

    // unsigned integer, saturate
    fp_mult_pipe_sat #(.WIDTH(8), .INT_WIDTH(8), .FRAC_WIDTH(0), .SIGNED(0),
        .STAGES(3), .ROUND(0), .SATURATE(1)) u_e (
        .clk(clk), .reset(reset), .left(left), .right(right), .go(go),
        .out(e_out), .done(e_done), .overflow(e_ovf));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // issue in cycle 0, return sampling cycle 3
    task automatic issue(input logic [7:0] l, input logic [7:0] r);
        left  = l;
        right = r;
        go    = 1'b1;
        step();
        go = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go    = 1'b1;
        left  = 8'h40;
        right = 8'h40;
        repeat (3) step();
        n_checks++;
        if (a_out !== 8'h00 || a_ovf !== 1'b0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: out=%h ovf=%b done=%b want 00/0/0",
                     a_out, a_ovf, a_done);
        end
        n_checks++;
        if (d_out !== 8'h00 || d_done !== 1'b0 || e_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_de: d_out=%h d_done=%b e_out=%h want 00/0/00",
                     d_out, d_done, e_out);
        end
        reset = 1'b0;
        go    = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (a_done !== 1'b0 || d_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_go_ignored: c=%0d a_done=%b d_done=%b want 0",
                         c, a_done, d_done);
            end
            step();
        end
    endtask

    task automatic test_basic();
        left  = 8'h18;
        right = 8'h24;
        go    = 1'b1;
        step();
        go = 1'b0;
        step();
        n_checks++;
        if (a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: done=%b in cycle 2 want 0", a_done);
        end
        step();
        n_checks++;
        if (a_done !== 1'b1 || a_out !== 8'h36 || a_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic: done=%b out=%h ovf=%b want 1/36/0",
                     a_done, a_out, a_ovf);
        end
        step();
        n_checks++;
        if (a_done !== 1'b0 || a_out !== 8'h36) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b out=%h want 0/36",
                     a_done, a_out);
        end
    endtask

    task automatic test_round();
        issue(8'h01, 8'h08);
        n_checks++;
        if (a_out !== 8'h00 || b_out !== 8'h01 || b_done !== 1'b1) begin
            n_fail++;
            $display("FAIL round_pos: trunc=%h round=%h done=%b want 00/01/1",
                     a_out, b_out, b_done);
        end
        issue(8'hFF, 8'h08);
        n_checks++;
        if (a_out !== 8'hFF || b_out !== 8'h00 || b_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL round_neg: trunc=%h round=%h ovf=%b want FF/00/0",
                     a_out, b_out, b_ovf);
        end
    endtask

    task automatic test_negative();
        issue(8'hE8, 8'h24);
        n_checks++;
        if (a_out !== 8'hCA || a_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL negative: out=%h ovf=%b want CA/0", a_out, a_ovf);
        end
    endtask

    task automatic test_saturate();
        issue(8'h40, 8'h40);
        n_checks++;
        if (c_out !== 8'h7F || c_ovf !== 1'b1 || c_done !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos: out=%h ovf=%b done=%b want 7F/1/1",
                     c_out, c_ovf, c_done);
        end
        n_checks++;
        if (a_out !== 8'h00 || a_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pos: out=%h ovf=%b want 00/1", a_out, a_ovf);
        end
        issue(8'hC0, 8'h40);
        n_checks++;
        if (c_out !== 8'h80 || c_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg: out=%h ovf=%b want 80/1", c_out, c_ovf);
        end
    endtask

    task automatic test_unsigned();
        issue(8'hFF, 8'hFF);
        n_checks++;
        if (e_out !== 8'hFF || e_ovf !== 1'b1 || e_done !== 1'b1) begin
            n_fail++;
            $display("FAIL uns_sat: out=%h ovf=%b done=%b want FF/1/1",
                     e_out, e_ovf, e_done);
        end
        issue(8'h0F, 8'h11);
        n_checks++;
        if (e_out !== 8'hFF || e_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL uns_fit: out=%h ovf=%b want FF/0", e_out, e_ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        logic [7:0] exp_out;
        repeat (4) step();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                exp_done = (c >= 5 && c <= 8);
                n_checks++;
                if (d_done !== exp_done) begin
                    n_fail++;
                    $display("FAIL b2b_done: cycle %0d done=%b want %b",
                             c, d_done, exp_done);
                end
                if (exp_done) begin
                    exp_out = 8'(c - 4);
                    n_checks++;
                    if (d_out !== exp_out || d_ovf !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b2b_out: cycle %0d out=%h ovf=%b want %h/0",
                                 c, d_out, d_ovf, exp_out);
                    end
                end
            end
            go    = (c < 4);
            left  = 8'(c + 1);
            right = 8'h01;
            step();
        end
        n_checks++;
        if (d_done !== 1'b0 || d_out !== 8'h04) begin
            n_fail++;
            $display("FAIL b2b_hold: done=%b out=%h want 0/04", d_done, d_out);
        end
    endtask

    task automatic test_reset_midflight();
        repeat (4) step();
        left  = 8'h18;
        right = 8'h24;
        go    = 1'b1;
        step();
        reset = 1'b1;
        left  = 8'h7F;
        step();
        n_checks++;
        if (a_out !== 8'h00 || a_done !== 1'b0 || d_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midflight_clear: a_out=%h a_done=%b d_out=%h want 00/0/00",
                     a_out, a_done, d_out);
        end
        reset = 1'b0;
        left  = 8'h10;
        right = 8'h03;
        step();
        go = 1'b0;
        for (int c = 3; c < 9; c++) begin
            n_checks++;
            if (a_done !== (c == 5) || d_done !== (c == 7)) begin
                n_fail++;
                $display("FAIL midflight_done: cycle %0d a=%b d=%b want %b/%b",
                         c, a_done, d_done, c == 5, c == 7);
            end
            if (c == 5) begin
                n_checks++;
                if (a_out !== 8'h03) begin
                    n_fail++;
                    $display("FAIL midflight_a_out: out=%h want 03", a_out);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (d_out !== 8'h30 || d_ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midflight_d_out: out=%h ovf=%b want 30/0",
                             d_out, d_ovf);
                end
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        left  = 8'h00;
        right = 8'h00;
        test_reset();
        test_basic();
        test_round();
        test_negative();
        test_saturate();
        test_unsigned();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe_sat.md
# fp_mult_pipe_sat

Fully pipelined, parametrised fixed-point multiplier with a go/done interface. It accepts one operand pair per cycle and returns each result exactly `STAGES` cycles after issue. Optional round-half-up and saturation are applied at the output, with an overflow flag. It is the throughput-1 successor to the existing fixed-point pipelined multipliers in the standard primitive library, for datapaths that issue back-to-back multiplies.

## Interface
- `WIDTH`, 16, operand and result width in bits.
- `INT_WIDTH`, 8, integer bits; `INT_WIDTH + FRAC_WIDTH == WIDTH` is required.
- `FRAC_WIDTH`, 8, fraction bits; may be 0.
- `SIGNED`, 1, 1 = two's complement operands and result, 0 = unsigned.
- `STAGES`, 3, total latency in cycles; must be ≥ 3.
- `ROUND`, 0, 0 = truncate, 1 = round half up (toward +inf on ties).
- `SATURATE`, 0, 0 = wrap on overflow, 1 = clamp to the representable max/min.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `left`, `right`  in  WIDTH  operands; sampled on a cycle where `go` = 1.
- `go`  in  1  issue strobe; each high cycle is one independent operation.
- `out`  out  WIDTH  result; valid while `done` = 1, otherwise holds the last result.
- `done`  out  1  one-cycle pulse per issued operation, in issue order.
- `overflow`  out  1  aligned with `done`: the result was not representable.

## Operation
- Valid pipe: a shift register of `STAGES` bits.
  - Bit 0 is loaded from `go` (with `reset` low).
  - `done` is the last bit.
- Stage 1 registers the operands.
- Stage 2 registers the full 2·WIDTH product.
  - Signed: both operands are sign-extended to 2·WIDTH before multiplying.
  - Unsigned: both operands are zero-extended.
- Stages 3..STAGES-1 delay the product. These registers exist for retiming only and add no logic.
- Final stage computes and registers the result into `out` and `overflow`:
  - `p` is the product, carried in 2·WIDTH+1 bits.
  - If `ROUND` = 1 and `FRAC_WIDTH` > 0: add 2^(FRAC_WIDTH-1) to `p`.
  - Shift arithmetically (signed) or logically (unsigned) right by `FRAC_WIDTH`.
  - Signed overflow: the bits above WIDTH-1 are not all copies of bit WIDTH-1.
  - Unsigned overflow: any bit above WIDTH-1 is nonzero.
  - `SATURATE` = 1: clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1) (signed), or to 2^WIDTH-1 (unsigned). Clamp direction follows the sign of `p`.
  - `SATURATE` = 0: take the low WIDTH bits.
- A data stage register loads only when its valid bit is set. `out` and `overflow` change only on cycles where `done` goes high.

## Timing
- Reset values: `out` = 0, `done` = 0, `overflow` = 0, all valid bits 0. Data registers also clear to 0.
- Latency: `go` high in cycle t gives `done` = 1 in cycle t+STAGES.
- Throughput: one operation per cycle. There is no backpressure; the consumer must accept `done` when it fires.
- Consecutive `go` cycles produce consecutive `done` pulses with no gaps.
- `go` is level-per-cycle, not a start edge. Holding `go` high for N cycles issues N operations.
- Reset mid-flight:
  - All in-flight operations are discarded, and none of them ever produces `done`.
  - `go` asserted in the same cycle as `reset` is ignored.
  - The first issue is possible in the cycle after `reset` deasserts.
- `overflow` is meaningful only while `done` = 1. It holds its value between pulses, together with `out`.

## Structure
- Package `fp_mult_pkg` holds:
  - `localparam` helpers for max/min saturation bounds as functions of WIDTH and SIGNED.
  - A rounding-constant function.
  - Parameter-legality checks, as an elaboration `$error` on a width mismatch or `STAGES` < 3.
- Sub-module `fp_round_sat` is purely combinational. It takes the 2·WIDTH+1-bit `p` and produces the WIDTH-bit result plus the overflow bit. It is instanced once, before the final register.
- The valid pipe and the data delay line live in the top module as generate loops.

## Test plan
- WIDTH=8, INT=4, FRAC=4, signed, STAGES=3, ROUND=0: `left`=0x18, `right`=0x24 issued in cycle 0 → `done`=1 in cycle 3, `out`=0x36, `overflow`=0.
- Same config with ROUND=1: 0x01 × 0x08 → `out`=0x01. With ROUND=0 → `out`=0x00.
- SATURATE=1: 0x40 × 0x40 → `out`=0x7F, `overflow`=1. 0xC0 × 0x40 → `out`=0x80, `overflow`=1. With SATURATE=0, 0x40 × 0x40 → `out`=0x00, `overflow`=1.
- STAGES=5: `go` high for 4 consecutive cycles, starting in cycle 0, with operands (1,1), (2,1), (3,1), (4,1) in integer format FRAC=0 → `done` high in cycles 5–8. `out` = 1, 2, 3, 4 in order.
- Reset mid-flight: `go` in cycle 0, `reset` in cycle 1 → `done` never asserts, `out`=0. A new `go` in cycle 2 → `done` in cycle 2+STAGES.
- SIGNED=0, WIDTH=8, FRAC=0, SATURATE=1: 0xFF × 0xFF → `out`=0xFF, `overflow`=1. 0x0F × 0x11 → `out`=0xFF, `overflow`=0.
